rvga_fetch: RTL

- Instruction fetch stage of the rvga core, directly upstream of decode.
- Fetches 128-bit cachelines from the instruction memory port and holds one line in a single-entry line buffer.
- Delivers one 32-bit instruction word plus its PC per valid/ready handshake to decode.
- Accepts PC redirects from branch/jump resolution.

---
 rtl/rvga_fetch_if.sv | 29 ++
 rtl/rvga_fetch.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rvga_fetch_if.sv
// rtl/rvga_fetch_if.sv - fetch stage memory, redirect and decode handshake bundle
interface rvga_fetch_if;
  logic         mem_req_v_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ready_i;
  logic         mem_resp_v_i;
  logic [127:0] mem_resp_data_i;
  logic         redirect_v_i;
  logic [31:0]  redirect_pc_i;
  logic         inst_v_o;
  logic [31:0]  inst_o;
  logic [31:0]  pc_o;
  logic         inst_ready_i;
  logic         inst_illegal_o;

  // fetch stage side
  modport master (
    output mem_req_v_o, mem_addr_o, inst_v_o, inst_o, pc_o, inst_illegal_o,
    input  mem_ready_i, mem_resp_v_i, mem_resp_data_i,
           redirect_v_i, redirect_pc_i, inst_ready_i
  );

  // memory / branch unit / decode side
  modport slave (
    input  mem_req_v_o, mem_addr_o, inst_v_o, inst_o, pc_o, inst_illegal_o,
    output mem_ready_i, mem_resp_v_i, mem_resp_data_i,
           redirect_v_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/rvga_fetch.sv
// rtl/rvga_fetch.sv - instruction fetch with single-line buffer; RVGA_FETCH_OPCODE_CHECK_EN adds opcode check
module rvga_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h10054,
  parameter int          LINE_BYTES = 16
) (
  input logic         clk_i,
  input logic         reset_n_i,
  rvga_fetch_if.master bus
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int WORDS    = LINE_BYTES / 4;

  typedef enum logic [1:0] {REQ, WAIT, SERVE, DRAIN} state_t;

  state_t                     state, state_n;
  logic [31:0]                pc, pc_n;
  logic [WORDS-1:0][31:0]     line, line_n;
  logic [31-OFF_BITS:0]       tag, tag_n;

  logic        req_q;
  logic [31:0] addr_q;
  logic        inst_v_q;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  logic        fire_req;
  logic        fire_inst;
  logic [31:0] redir_pc;

  assign fire_req  = req_q & bus.mem_ready_i;
  assign fire_inst = inst_v_q & bus.inst_ready_i;
  assign redir_pc  = {bus.redirect_pc_i[31:2], 2'b00};

  // Next-state: a redirect overrides every other event; leaving SERVE invalidates the line.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    line_n  = line;
    tag_n   = tag;
    case (state)
      REQ: begin
        if (bus.redirect_v_i) begin
          pc_n    = redir_pc;
          state_n = fire_req ? DRAIN : REQ;
        end else if (fire_req) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_v_i) begin
          pc_n    = redir_pc;
          state_n = bus.mem_resp_v_i ? REQ : DRAIN;
        end else if (bus.mem_resp_v_i) begin
          line_n  = bus.mem_resp_data_i;
          tag_n   = pc[31:OFF_BITS];
          state_n = SERVE;
        end
      end
      SERVE: begin
        if (bus.redirect_v_i) begin
          pc_n = redir_pc;
          if (redir_pc[31:OFF_BITS] != tag) state_n = REQ;
        end else if (fire_inst) begin
          pc_n = pc + 32'd4;
          if (&pc[OFF_BITS-1:2]) state_n = REQ;
        end
      end
      DRAIN: begin
        if (bus.redirect_v_i) pc_n = redir_pc;
        if (bus.mem_resp_v_i) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
  end

  // State, line buffer and Moore outputs, all registered from the next-state values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= REQ;
      pc       <= RESET_PC;
      line     <= '0;
      tag      <= '0;
      req_q    <= 1'b0;
      addr_q   <= {RESET_PC[31:OFF_BITS], {OFF_BITS{1'b0}}};
      inst_v_q <= 1'b0;
      inst_q   <= '0;
      pc_q     <= RESET_PC;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      line     <= line_n;
      tag      <= tag_n;
      req_q    <= (state_n == REQ);
      addr_q   <= {pc_n[31:OFF_BITS], {OFF_BITS{1'b0}}};
      inst_v_q <= (state_n == SERVE);
      inst_q   <= line_n[pc_n[OFF_BITS-1:2]];
      pc_q     <= pc_n;
    end
  end

  assign bus.mem_req_v_o = req_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.inst_v_o    = inst_v_q;
  assign bus.inst_o      = inst_q;
  assign bus.pc_o        = pc_q;

`ifdef RVGA_FETCH_OPCODE_CHECK_EN
  logic opcode_ok;

  // Every defined opcode ends in 2'b11, so matching the full 7 bits also rejects compressed encodings.
  always_comb begin
    opcode_ok = 1'b0;
    case (inst_q[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
      7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: opcode_ok = 1'b1;
      default: opcode_ok = 1'b0;
    endcase
  end

  assign bus.inst_illegal_o = inst_v_q & ~opcode_ok;
`else
  assign bus.inst_illegal_o = 1'b0;
`endif

endmodule
